mips_regfile_sb: RTL and testbench

MIPS_REGFILE_SB -- requirements
Module: mips_regfile_sb

---
 rtl/mips_regfile_sb_if.sv | 31 +++
 rtl/mips_regfile_sb.sv | 98 +++++++++
 tb/tb_mips_regfile_sb.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_regfile_sb_if.sv
// Bus bundle for the MIPS register file with issue scoreboard: two read ports,
// one write port, one reserve port and the scoreboard status outputs.
interface mips_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] read_reg_1;
  logic [ADDR_W-1:0] read_reg_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              signal_reg_write;
  logic [ADDR_W-1:0] reserve_reg;
  logic              signal_reserve;
  logic              busy_1;
  logic              busy_2;
  logic [ADDR_W:0]   pending_cnt;

  modport master (
    output read_reg_1, read_reg_2, write_reg, write_data, signal_reg_write,
           reserve_reg, signal_reserve,
    input  read_data_1, read_data_2, busy_1, busy_2, pending_cnt
  );

  modport slave (
    input  read_reg_1, read_reg_2, write_reg, write_data, signal_reg_write,
           reserve_reg, signal_reserve,
    output read_data_1, read_data_2, busy_1, busy_2, pending_cnt
  );
endinterface

// File: rtl/mips_regfile_sb.sv
// MIPS register file with a per-register busy scoreboard and a pending count.
// Optional write-through forwarding on the read ports: `define MIPS_REGFILE_BYPASS_EN.
module mips_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic              clk,
  input logic              rst_n,
  mips_regfile_sb_if.slave rf
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NREG - 1);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              wr_en;
  logic              rsv_en;
  logic              cnt_inc;
  logic              cnt_dec;
  logic              fwd_1;
  logic              fwd_2;

  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt,
                                                 input logic inc,
                                                 input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec && cnt != CNT_MAX)
      res = cnt + CNT_ONE;
    else if (dec && !inc && cnt != '0)
      res = cnt - CNT_ONE;
    return res;
  endfunction

  // Register 0 is excluded from both enables, so it is never written nor busy.
  always_comb begin
    wr_en    = rst_n && rf.signal_reg_write && (rf.write_reg != '0);
    rsv_en   = rst_n && rf.signal_reserve && (rf.reserve_reg != '0);
    busy_nxt = busy_q;
    if (wr_en)
      busy_nxt[rf.write_reg] = 1'b0;
    if (rsv_en)
      busy_nxt[rf.reserve_reg] = 1'b1;
    // Count only real transitions of a busy bit; a same-index reserve overrides the clear.
    cnt_inc = rsv_en && !busy_q[rf.reserve_reg];
    cnt_dec = wr_en && busy_q[rf.write_reg] &&
              !(rsv_en && (rf.reserve_reg == rf.write_reg));
    cnt_nxt = sat_count(cnt_q, cnt_inc, cnt_dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      busy_q <= busy_nxt;
      cnt_q  <= cnt_nxt;
      if (wr_en)
        regs[rf.write_reg] <= rf.write_data;
    end
  end

  always_comb begin
`ifdef MIPS_REGFILE_BYPASS_EN
    fwd_1 = wr_en && (rf.write_reg == rf.read_reg_1);
    fwd_2 = wr_en && (rf.write_reg == rf.read_reg_2);
`else
    fwd_1 = 1'b0;
    fwd_2 = 1'b0;
`endif
    rf.read_data_1 = '0;
    rf.busy_1      = 1'b0;
    rf.read_data_2 = '0;
    rf.busy_2      = 1'b0;
    if (fwd_1) begin
      rf.read_data_1 = rf.write_data;
    end else if (rf.read_reg_1 != '0) begin
      rf.read_data_1 = regs[rf.read_reg_1];
      rf.busy_1      = busy_q[rf.read_reg_1];
    end
    if (fwd_2) begin
      rf.read_data_2 = rf.write_data;
    end else if (rf.read_reg_2 != '0) begin
      rf.read_data_2 = regs[rf.read_reg_2];
      rf.busy_2      = busy_q[rf.read_reg_2];
    end
  end

  assign rf.pending_cnt = cnt_q;

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Randomised and directed bench for mips_regfile_sb against an array-based model
// of the register contents and busy set.
module tb_mips_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [DW-1:0] m_regs [32];
  bit   [31:0]   m_busy;

  mips_regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();

  mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_count();
    int c;
    c = 0;
    for (int i = 0; i < 32; i++)
      if (m_busy[i]) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] r);
    if (r == 0) return '0;
`ifdef MIPS_REGFILE_BYPASS_EN
    if (rst_n && bif.signal_reg_write && bif.write_reg == r) return bif.write_data;
`endif
    return m_regs[r];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] r);
    if (r == 0) return 1'b0;
`ifdef MIPS_REGFILE_BYPASS_EN
    if (rst_n && bif.signal_reg_write && bif.write_reg == r) return 1'b0;
`endif
    return m_busy[r];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                       input logic rs, input logic [AW-1:0] rsv,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bif.signal_reg_write = we;
    bif.write_reg        = wr;
    bif.write_data       = wd;
    bif.signal_reserve   = rs;
    bif.reserve_reg      = rsv;
    bif.read_reg_1       = r1;
    bif.read_reg_2       = r2;
  endtask

  // Advance one edge and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (bif.signal_reg_write && bif.write_reg != 0) begin
        m_regs[bif.write_reg] = bif.write_data;
        m_busy[bif.write_reg] = 1'b0;
      end
      if (bif.signal_reserve && bif.reserve_reg != 0)
        m_busy[bif.reserve_reg] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_clear();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    for (int i = 0; i < 32; i++) begin
      bif.read_reg_1 = AW'(i);
      bif.read_reg_2 = AW'(31 - i);
      #1;
      n_checks += 4;
      if (bif.read_data_1 !== '0) begin n_fail++; $display("FAIL reset_rd1[%0d] got %h want 0", i, bif.read_data_1); end
      if (bif.read_data_2 !== '0) begin n_fail++; $display("FAIL reset_rd2[%0d] got %h want 0", 31 - i, bif.read_data_2); end
      if (bif.busy_1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1[%0d] got %b want 0", i, bif.busy_1); end
      if (bif.busy_2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy2[%0d] got %b want 0", 31 - i, bif.busy_2); end
    end
    n_checks++;
    if (bif.pending_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bif.pending_cnt); end
    drive(1, 5, 32'hFFFF_FFFF, 1, 6, 5, 6);
    tick();
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 5, 6);
    #1;
    n_checks += 2;
    if (bif.read_data_1 !== '0) begin n_fail++; $display("FAIL reset_ignored_wr got %h want 0", bif.read_data_1); end
    if (bif.busy_2 !== 1'b0) begin n_fail++; $display("FAIL reset_ignored_rsv got %b want 0", bif.busy_2); end
    tick();
    n_checks++;
    if (bif.pending_cnt !== '0) begin n_fail++; $display("FAIL post_reset_cnt got %0d want 0", bif.pending_cnt); end
  endtask

  task automatic test_reg0();
    drive(1, 0, 32'hDEAD_BEEF, 1, 0, 0, 0);
    #1;
    n_checks += 2;
    if (bif.read_data_1 !== '0) begin n_fail++; $display("FAIL reg0_pre got %h want 0", bif.read_data_1); end
    if (bif.busy_1 !== 1'b0) begin n_fail++; $display("FAIL reg0_busy_pre got %b want 0", bif.busy_1); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks += 3;
    if (bif.read_data_1 !== '0) begin n_fail++; $display("FAIL reg0_rd1 got %h want 0", bif.read_data_1); end
    if (bif.read_data_2 !== '0) begin n_fail++; $display("FAIL reg0_rd2 got %h want 0", bif.read_data_2); end
    if (bif.pending_cnt !== '0) begin n_fail++; $display("FAIL reg0_cnt got %0d want 0", bif.pending_cnt); end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] pre_exp;
`ifdef MIPS_REGFILE_BYPASS_EN
    pre_exp = 32'h1234_5678;
`else
    pre_exp = 32'h0;
`endif
    drive(1, 9, 32'h1234_5678, 0, 0, 9, 8);
    #1;
    n_checks += 2;
    if (bif.read_data_1 !== pre_exp) begin n_fail++; $display("FAIL wr9_pre_edge got %h want %h", bif.read_data_1, pre_exp); end
    if (bif.read_data_2 !== '0) begin n_fail++; $display("FAIL wr9_other_port got %h want 0", bif.read_data_2); end
    tick();
    drive(0, 0, 0, 0, 0, 9, 9);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks += 2;
      if (bif.read_data_1 !== 32'h1234_5678) begin n_fail++; $display("FAIL wr9_rd1 cyc%0d got %h want 12345678", k, bif.read_data_1); end
      if (bif.read_data_2 !== 32'h1234_5678) begin n_fail++; $display("FAIL wr9_rd2 cyc%0d got %h want 12345678", k, bif.read_data_2); end
      tick();
    end
  endtask

  task automatic test_scoreboard();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, AW'(3 + i), AW'(3 + i), 0);
      tick();
      drive(0, 0, 0, 0, 0, AW'(3 + i), 0);
      #1;
      n_checks += 2;
      if (bif.pending_cnt !== 6'(i + 1)) begin n_fail++; $display("FAIL sb_cnt_rsv%0d got %0d want %0d", 3 + i, bif.pending_cnt, i + 1); end
      if (bif.busy_1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy_rsv%0d got %b want 1", 3 + i, bif.busy_1); end
    end
    drive(1, 4, 32'h0000_0044, 0, 0, 4, 3);
    tick();
    drive(0, 0, 0, 0, 0, 4, 3);
    #1;
    n_checks += 4;
    if (bif.busy_1 !== 1'b0) begin n_fail++; $display("FAIL sb_wr4_busy got %b want 0", bif.busy_1); end
    if (bif.read_data_1 !== 32'h44) begin n_fail++; $display("FAIL sb_wr4_data got %h want 44", bif.read_data_1); end
    if (bif.busy_2 !== 1'b1) begin n_fail++; $display("FAIL sb_reg3_busy got %b want 1", bif.busy_2); end
    if (bif.pending_cnt !== 6'd2) begin n_fail++; $display("FAIL sb_wr4_cnt got %0d want 2", bif.pending_cnt); end
    drive(0, 0, 0, 1, 3, 3, 0);
    tick();
    #1;
    n_checks += 2;
    if (bif.pending_cnt !== 6'd2) begin n_fail++; $display("FAIL sb_rersv3_cnt got %0d want 2", bif.pending_cnt); end
    if (bif.busy_1 !== 1'b1) begin n_fail++; $display("FAIL sb_rersv3_busy got %b want 1", bif.busy_1); end
  endtask

  task automatic test_same_cycle();
    int cnt0;
    cnt0 = m_count();
    drive(1, 7, 32'hA5A5_A5A5, 1, 7, 7, 7);
    #1;
    n_checks += 2;
    if (bif.busy_1 !== 1'b0) begin n_fail++; $display("FAIL same_pre_busy1 got %b want 0", bif.busy_1); end
    if (bif.read_data_2 !== exp_rd(7)) begin n_fail++; $display("FAIL same_pre_rd2 got %h want %h", bif.read_data_2, exp_rd(7)); end
    tick();
    drive(0, 0, 0, 0, 0, 7, 7);
    #1;
    n_checks += 5;
    if (bif.read_data_1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL same_rd1 got %h want a5a5a5a5", bif.read_data_1); end
    if (bif.read_data_2 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL same_rd2 got %h want a5a5a5a5", bif.read_data_2); end
    if (bif.busy_1 !== 1'b1) begin n_fail++; $display("FAIL same_busy1 got %b want 1", bif.busy_1); end
    if (bif.busy_2 !== 1'b1) begin n_fail++; $display("FAIL same_busy2 got %b want 1", bif.busy_2); end
    if (bif.pending_cnt !== 6'(cnt0 + 1)) begin n_fail++; $display("FAIL same_cnt got %0d want %0d", bif.pending_cnt, cnt0 + 1); end
  endtask

  task automatic test_saturation();
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 0, 1, AW'(i), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (bif.pending_cnt !== 6'd31) begin n_fail++; $display("FAIL sat_all got %0d want 31", bif.pending_cnt); end
    drive(0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 17, 0, 0);
    tick();
    n_checks++;
    if (bif.pending_cnt !== 6'd31) begin n_fail++; $display("FAIL sat_extra got %0d want 31", bif.pending_cnt); end
    for (int i = 0; i < 32; i++) begin
      bif.read_reg_1 = AW'(i);
      #1;
      n_checks++;
      if (bif.busy_1 !== exp_busy(AW'(i))) begin n_fail++; $display("FAIL sat_busy[%0d] got %b want %b", i, bif.busy_1, exp_busy(AW'(i))); end
    end
  endtask

  task automatic test_async_reset();
    #1 rst_n = 1'b0;
    m_clear();
    #1 rst_n = 1'b1;
    drive(1, 10, 32'hCAFE_0010, 0, 0, 0, 0);
    tick();
    for (int i = 11; i < 16; i++) begin
      drive(0, 0, 0, 1, AW'(i), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 10, 11);
    #1;
    n_checks += 3;
    if (bif.pending_cnt !== 6'd5) begin n_fail++; $display("FAIL ar_pre_cnt got %0d want 5", bif.pending_cnt); end
    if (bif.read_data_1 !== 32'hCAFE_0010) begin n_fail++; $display("FAIL ar_pre_rd1 got %h want cafe0010", bif.read_data_1); end
    if (bif.busy_2 !== 1'b1) begin n_fail++; $display("FAIL ar_pre_busy2 got %b want 1", bif.busy_2); end
    #1 rst_n = 1'b0;
    m_clear();
    #1;
    n_checks += 3;
    if (bif.pending_cnt !== '0) begin n_fail++; $display("FAIL ar_cnt got %0d want 0", bif.pending_cnt); end
    if (bif.read_data_1 !== '0) begin n_fail++; $display("FAIL ar_rd1 got %h want 0", bif.read_data_1); end
    if (bif.busy_2 !== 1'b0) begin n_fail++; $display("FAIL ar_busy2 got %b want 0", bif.busy_2); end
    drive(0, 0, 0, 1, 12, 12, 0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(0, 0, 0, 0, 0, 12, 0);
    #1;
    n_checks += 2;
    if (bif.pending_cnt !== 6'd1) begin n_fail++; $display("FAIL ar_release_cnt got %0d want 1", bif.pending_cnt); end
    if (bif.busy_1 !== 1'b1) begin n_fail++; $display("FAIL ar_release_busy got %b want 1", bif.busy_1); end
  endtask

  task automatic test_random();
    logic [AW-1:0] wr, rsv, r1, r2;
    for (int c = 0; c < 400; c++) begin
      wr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      rsv = ($urandom_range(0, 4) == 0) ? wr : AW'($urandom_range(0, 7));
      r1  = ($urandom_range(0, 3) == 0) ? wr : AW'($urandom_range(0, 9));
      r2  = ($urandom_range(0, 3) == 0) ? r1 : AW'($urandom_range(0, 9));
      drive(1'($urandom_range(0, 1)), wr, $urandom, 1'($urandom_range(0, 2) == 0), rsv, r1, r2);
      #1;
      n_checks += 4;
      if (bif.read_data_1 !== exp_rd(r1)) begin n_fail++; $display("FAIL rnd%0d_rd1 r%0d got %h want %h", c, r1, bif.read_data_1, exp_rd(r1)); end
      if (bif.read_data_2 !== exp_rd(r2)) begin n_fail++; $display("FAIL rnd%0d_rd2 r%0d got %h want %h", c, r2, bif.read_data_2, exp_rd(r2)); end
      if (bif.busy_1 !== exp_busy(r1)) begin n_fail++; $display("FAIL rnd%0d_busy1 r%0d got %b want %b", c, r1, bif.busy_1, exp_busy(r1)); end
      if (bif.busy_2 !== exp_busy(r2)) begin n_fail++; $display("FAIL rnd%0d_busy2 r%0d got %b want %b", c, r2, bif.busy_2, exp_busy(r2)); end
      tick();
      n_checks++;
      if (bif.pending_cnt !== 6'(m_count())) begin n_fail++; $display("FAIL rnd%0d_cnt got %0d want %0d", c, bif.pending_cnt, m_count()); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_reg0();
    test_write_read();
    test_scoreboard();
    test_same_cycle();
    test_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
